// File: rtl/strobe_scheduler.sv
// strobe_scheduler: captures per-channel event strobes with a free-running
// timestamp and drains them one record at a time through a valid/ready port,
// choosing among pending channels in round-robin order.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   strobe[N_CH]         one-cycle event pulses, one per channel
//   en                   capture enable (low: strobes ignored)
//   ts_clr               synchronous clear of the timestamp counter
//   out_valid/out_ready  record handshake
//   out_ch, out_ts       channel and capture timestamp of the record
//   out_lost             events were dropped on out_ch since its last record
//   lost_cnt             saturating count of all dropped events
//
// Optional feature: define TT_DEADTIME_EN to add parameter DEAD and a
// per-channel dead-time window during which further strobes are ignored.
module strobe_scheduler #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned TS_W = 32,
  parameter int unsigned CH_W = 2
`ifdef TT_DEADTIME_EN
  ,
  parameter int unsigned DEAD = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] strobe,
  input  logic            en,
  input  logic            ts_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [TS_W-1:0] out_ts,
  output logic            out_lost,
  output logic [7:0]      lost_cnt
);

  localparam int unsigned LOST_W  = 8;
  localparam int unsigned NDROP_W = 5;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [TS_W-1:0]     pend_ts_q [N_CH];
  logic [TS_W-1:0]     pend_ts_d [N_CH];
  logic [N_CH-1:0]     drop_q, drop_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [TS_W-1:0]     out_ts_q, out_ts_d;
  logic                out_lost_q, out_lost_d;
`ifdef TT_DEADTIME_EN
  localparam int unsigned DEAD_W = 8;
  logic [DEAD_W-1:0]   dead_q [N_CH];
  logic [DEAD_W-1:0]   dead_d [N_CH];
`endif

  // Grant search and next-state signals
  logic                gnt_vld_c;
  logic [CH_W-1:0]     gnt_idx_c;
  int unsigned         idx_c;
  logic                load_c;
  logic                cap_c;
  logic [NDROP_W-1:0]  n_drop_c;
  logic [LOST_W:0]     lost_sum_c;

  // Round-robin search: first pending channel at or after ptr, wrapping
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    idx_c     = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx_c = (32'(ptr_q) + k) % N_CH;
      if (!gnt_vld_c && pend_q[CH_W'(idx_c)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = CH_W'(idx_c);
      end
    end
  end

  // Next-state: timestamp, output stage, pending capture and drop accounting
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + TS_W'(1);
    pend_d     = pend_q;
    pend_ts_d  = pend_ts_q;
    drop_d     = drop_q;
    ptr_d      = ptr_q;
    lost_d     = lost_q;
    out_ch_d   = out_ch_q;
    out_ts_d   = out_ts_q;
    out_lost_d = out_lost_q;
    n_drop_c   = '0;
    cap_c      = 1'b0;
    lost_sum_c = '0;
`ifdef TT_DEADTIME_EN
    for (int unsigned i = 0; i < N_CH; i++) begin
      dead_d[i] = (dead_q[i] == '0) ? '0 : dead_q[i] - DEAD_W'(1);
    end
`endif

    if (ts_clr) begin
      ts_d = '0;
    end

    // Output register may reload when empty or when the held record is taken
    load_c = (state_q == S_EMPTY) || out_ready;

    if (load_c) begin
      if (gnt_vld_c) begin
        state_d              = S_FULL;
        out_ch_d             = gnt_idx_c;
        out_ts_d             = pend_ts_q[gnt_idx_c];
        out_lost_d           = drop_q[gnt_idx_c];
        pend_d[gnt_idx_c]    = 1'b0;
        drop_d[gnt_idx_c]    = 1'b0;
        ptr_d                = (32'(gnt_idx_c) == N_CH - 1) ? '0 : gnt_idx_c + CH_W'(1);
      end else begin
        state_d = S_EMPTY;
      end
    end

    // A channel being granted this cycle frees its slot, so a new strobe
    // there is captured rather than dropped
    for (int unsigned i = 0; i < N_CH; i++) begin
      cap_c = strobe[i] && en;
`ifdef TT_DEADTIME_EN
      cap_c = cap_c && (dead_q[i] == '0);
`endif
      if (cap_c) begin
        if (pend_q[i] && !(load_c && gnt_vld_c && (gnt_idx_c == CH_W'(i)))) begin
          drop_d[i] = 1'b1;
          n_drop_c  = n_drop_c + NDROP_W'(1);
        end else begin
          pend_d[i]    = 1'b1;
          pend_ts_d[i] = ts_q;
`ifdef TT_DEADTIME_EN
          // Window covers the capture cycle plus DEAD-1 following cycles
          dead_d[i]    = DEAD_W'(DEAD - 1);
`endif
        end
      end
    end

    lost_sum_c = (LOST_W + 1)'(lost_q) + (LOST_W + 1)'(n_drop_c);
    lost_d     = lost_sum_c[LOST_W] ? {LOST_W{1'b1}} : lost_sum_c[LOST_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      ts_q       <= '0;
      pend_q     <= '0;
      pend_ts_q  <= '{default: '0};
      drop_q     <= '0;
      ptr_q      <= '0;
      lost_q     <= '0;
      out_ch_q   <= '0;
      out_ts_q   <= '0;
      out_lost_q <= 1'b0;
`ifdef TT_DEADTIME_EN
      dead_q     <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      pend_q     <= pend_d;
      pend_ts_q  <= pend_ts_d;
      drop_q     <= drop_d;
      ptr_q      <= ptr_d;
      lost_q     <= lost_d;
      out_ch_q   <= out_ch_d;
      out_ts_q   <= out_ts_d;
      out_lost_q <= out_lost_d;
`ifdef TT_DEADTIME_EN
      dead_q     <= dead_d;
`endif
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_ch    = out_ch_q;
  assign out_ts    = out_ts_q;
  assign out_lost  = out_lost_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_strobe_scheduler.sv
// Testbench for strobe_scheduler: directed strobe patterns; expected records
// are queued as stimulus is issued and a monitor checks each handshake.
module tb_strobe_scheduler;

  localparam int unsigned N_CH = 4;
  localparam int unsigned TS_W = 8;
  localparam int unsigned CH_W = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] strobe;
  logic            en;
  logic            ts_clr;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [TS_W-1:0] out_ts;
  logic            out_lost;
  logic [7:0]      lost_cnt;

  strobe_scheduler #(
    .N_CH(N_CH),
    .TS_W(TS_W),
    .CH_W(CH_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe),
    .en       (en),
    .ts_clr   (ts_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_ts   (out_ts),
    .out_lost (out_lost),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;
    logic            lost;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference timestamp: what the counter should hold during the current cycle
  logic [TS_W-1:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tb_ts <= '0;
    else if (ts_clr) tb_ts <= '0;
    else             tb_ts <= tb_ts + 8'd1;
  end

  function automatic rec_t mk(input int ch, input int ts, input int lost);
    rec_t r;
    r.ch   = CH_W'(ch);
    r.ts   = TS_W'(ts);
    r.lost = 1'(lost);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted record must match the head of the queue
  always @(negedge clk) begin : mon
    rec_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record: got ch=%0d ts=%0d lost=%0d expected none",
                 out_ch, out_ts, out_lost);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_ts, out_lost} !== e) begin
          failures++;
          $display("FAIL record: got ch=%0d ts=%0d lost=%0d expected ch=%0d ts=%0d lost=%0d",
                   out_ch, out_ts, out_lost, e.ch, e.ts, e.lost);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] t);
    for (int n = 0; n < 600; n++) begin
      if (tb_ts == t) return;
      cyc();
    end
    checks++;
    failures++;
    $display("FAIL wait_ts_timeout: got ts=%0d expected ts=%0d", tb_ts, t);
  endtask

  task automatic pulse(input logic [N_CH-1:0] s);
    strobe = s;
    cyc();
    strobe = '0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    strobe    = '0;
    en        = 1'b1;
    ts_clr    = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ch",    32'(out_ch),    32'd0);
    check("rst_ts",    32'(out_ts),    32'd0);
    check("rst_lost",  32'(out_lost),  32'd0);
    check("rst_lostcnt", 32'(lost_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Single strobe, one-cycle latency
    out_ready = 1'b1;
    wait_ts(8'd5);
    exp_q.push_back(mk(1, 5, 0));
    pulse(4'b0010);
    check("lat_before", 32'(out_valid), 32'd0);
    cyc();
    check("lat_after", 32'(out_valid), 32'd1);
    drain("drain_single");

    // All channels at once: back-to-back records in index order
    do_reset();
    out_ready = 1'b1;
    wait_ts(8'd10);
    for (int c = 0; c < 4; c++) exp_q.push_back(mk(c, 10, 0));
    pulse(4'b1111);
    repeat (5) cyc();
    check("throughput", 32'(exp_q.size()), 32'd0);
    drain("drain_all");
    // Pointer back at 0: channel 0 wins over 3
    wait_ts(8'd20);
    exp_q.push_back(mk(0, 20, 0));
    exp_q.push_back(mk(3, 20, 0));
    pulse(4'b1001);
    drain("drain_ptr");

    // Backpressure: held record, pending event, then a dropped event
    do_reset();
    out_ready = 1'b0;
    wait_ts(8'd3);
    exp_q.push_back(mk(2, 3, 0));
    pulse(4'b0100);
    wait_ts(8'd6);
    exp_q.push_back(mk(2, 6, 1));
    pulse(4'b0100);
    check("hold1", 32'({out_valid, out_ch, out_ts, out_lost}), 32'({1'b1, 2'd2, 8'd3, 1'b0}));
    wait_ts(8'd8);
    pulse(4'b0100);
    check("hold2", 32'({out_valid, out_ch, out_ts, out_lost}), 32'({1'b1, 2'd2, 8'd3, 1'b0}));
    check("lost_one", 32'(lost_cnt), 32'd1);
    out_ready = 1'b1;
    drain("drain_drop");

    // Timestamp clear, then wrap with a same-channel strobe on the grant cycle
    do_reset();
    out_ready = 1'b1;
    wait_ts(8'd100);
    ts_clr = 1'b1;
    cyc();
    ts_clr = 1'b0;
    exp_q.push_back(mk(0, 0, 0));
    pulse(4'b0001);
    drain("drain_clr");
    wait_ts(8'd255);
    exp_q.push_back(mk(1, 255, 0));
    exp_q.push_back(mk(1, 0, 0));
    strobe = 4'b0010;
    cyc();
    cyc();
    strobe = '0;
    drain("drain_wrap");
    check("lost_wrap", 32'(lost_cnt), 32'd0);

    // Asynchronous reset while a record is held and others pending
    do_reset();
    out_ready = 1'b0;
    wait_ts(8'd2);
    pulse(4'b0001);
    wait_ts(8'd5);
    pulse(4'b0110);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({out_valid, out_ch, out_ts, out_lost, lost_cnt}), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("no_rec_after_reset", 32'(out_valid), 32'd0);

    // Repeated strobes on one channel
    do_reset();
    out_ready = 1'b1;
`ifdef TT_DEADTIME_EN
    exp_q.push_back(mk(3, 20, 0));
    exp_q.push_back(mk(3, 24, 0));
`else
    exp_q.push_back(mk(3, 20, 0));
    exp_q.push_back(mk(3, 22, 0));
    exp_q.push_back(mk(3, 24, 0));
`endif
    wait_ts(8'd20);
    pulse(4'b1000);
    wait_ts(8'd22);
    pulse(4'b1000);
    wait_ts(8'd24);
    pulse(4'b1000);
    drain("drain_repeat");
    check("lost_repeat", 32'(lost_cnt), 32'd0);

    // Capture disabled
    en = 1'b0;
    wait_ts(8'd50);
    pulse(4'b0010);
    en = 1'b1;
    repeat (4) cyc();
    check("en_low", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
